dmem_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: port 0 (core LSU) and port 1 (debug/program loader). Uses round-robin arbitration with one outstanding transaction at a time. Latches the winning request, issues it to memory, waits the read latency, then returns a completion pulse. Drives core_stall so the program counter holds while the core's access is in flight.

---
 rtl/dmem_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core LSU
// (port 0) and the debug/program loader (port 1). It keeps one transaction
// in flight at a time and picks the next owner round-robin when both ports
// ask at once.
//
// Flow per transaction: IDLE (arbitrate and latch) -> ISSUE (mem_en) ->
// WAIT (reads only, RD_LATENCY cycles) -> DONE (one-cycle done pulse).
// A misaligned or reserved-size request goes straight from IDLE to DONE with
// err set and never strobes the memory.
//
// Parameters:
//   RD_LATENCY  cycles from a read's mem_en to valid mem_rdata (1..15)
//   STAT_WIDTH  width of the per-port grant counters
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   mX_req/we/addr/size/wdata  request from port X (held until that done)
//   mX_gnt                  port X owns the memory (ISSUE..DONE)
//   mX_done/err/rdata       completion pulse, reject flag and load data
//   mem_en/we/addr/size/wdata  memory request; fields hold the last latch
//   mem_rdata               memory read data
//   core_stall              m0_req & ~m0_done
//
// Optional build macro DMEM_ARB_STATS_EN adds m0_count/m1_count: saturating
// counts of successful (err=0) completions per port.
module dmem_arbiter #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        core_stall
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] m0_count,
  output logic [STAT_WIDTH-1:0] m1_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $error("dmem_arbiter: RD_LATENCY must be in 1..15");
  end
  if (STAT_WIDTH < 1) begin : g_bad_stat_width
    $error("dmem_arbiter: STAT_WIDTH must be at least 1");
  end

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Winner of the current IDLE cycle and its request fields.
  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  always_comb begin
    // On a tie the port that did not win last time goes first.
    win       = (m0_req && m1_req) ? ~last_q : m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_size  = win ? m1_size  : m0_size;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_bad   = (sel_size == 2'd3) ||
                (sel_size == 2'd1 && sel_addr[0]) ||
                (sel_size == 2'd2 && sel_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = win;
          last_d  = win;
          we_d    = sel_we;
          addr_d  = sel_addr;
          size_d  = sel_size;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = sel_bad;
          state_d = sel_bad ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic busy;
  logic done;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  assign m0_gnt   = busy && !owner_q;
  assign m1_gnt   = busy &&  owner_q;
  assign m0_done  = done && !owner_q;
  assign m1_done  = done &&  owner_q;
  assign m0_err   = m0_done && err_q;
  assign m1_err   = m1_done && err_q;
  assign m0_rdata = m0_done ? rdata_q : '0;
  assign m1_rdata = m1_done ? rdata_q : '0;

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_size  = size_q;
  assign mem_wdata = wdata_q;

  assign core_stall = m0_req && !m0_done;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [STAT_WIDTH-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (m0_done && !err_q && !(&cnt0_q)) cnt0_d = cnt0_q + STAT_WIDTH'(1);
    if (m1_done && !err_q && !(&cnt1_q)) cnt1_d = cnt1_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign m0_count = cnt0_q;
  assign m1_count = cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LATENCY 1 and 3) driven by
// directed requests. A transaction-level model predicts every output each
// cycle; directed literal expectations pin latency, data and grant order.
module tb_dmem_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk;
  logic reset;

  logic        req      [2][2];
  logic        we_in    [2][2];
  logic [31:0] addr_in  [2][2];
  logic [1:0]  size_in  [2][2];
  logic [31:0] wdata_in [2][2];

  logic        gnt   [2][2];
  logic        done  [2][2];
  logic        err   [2][2];
  logic [31:0] rdata [2][2];

  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [1:0]  mem_size  [2];
  logic [31:0] mem_wdata [2];
  logic        stall     [2];
  logic [31:0] mem_rdata_a;
  logic [31:0] mem_rdata_b;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] count [2][2];
`endif

  bit [31:0]   store [64];
  int unsigned cyc;
  int          errs;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: real word memory. Instance B: read data is a cycle stamp so
  // the exact sampling cycle is visible in the returned value.
  assign mem_rdata_a = store[mem_addr[0][7:2]];
  assign mem_rdata_b = {16'hC0DE, cyc[15:0]};
  always @(posedge clk)
    if (mem_en[0] === 1'b1 && mem_we[0] === 1'b1) store[mem_addr[0][7:2]] <= mem_wdata[0];

  dmem_arbiter #(.RD_LATENCY(LAT_A), .STAT_WIDTH(16)) u_a (
    .clk(clk), .reset(reset),
    .m0_req(req[0][0]), .m0_we(we_in[0][0]), .m0_addr(addr_in[0][0]),
    .m0_size(size_in[0][0]), .m0_wdata(wdata_in[0][0]),
    .m1_req(req[0][1]), .m1_we(we_in[0][1]), .m1_addr(addr_in[0][1]),
    .m1_size(size_in[0][1]), .m1_wdata(wdata_in[0][1]),
    .m0_gnt(gnt[0][0]), .m0_done(done[0][0]), .m0_err(err[0][0]), .m0_rdata(rdata[0][0]),
    .m1_gnt(gnt[0][1]), .m1_done(done[0][1]), .m1_err(err[0][1]), .m1_rdata(rdata[0][1]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_size(mem_size[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata_a),
    .core_stall(stall[0])
`ifdef DMEM_ARB_STATS_EN
    , .m0_count(count[0][0]), .m1_count(count[0][1])
`endif
  );

  dmem_arbiter #(.RD_LATENCY(LAT_B), .STAT_WIDTH(16)) u_b (
    .clk(clk), .reset(reset),
    .m0_req(req[1][0]), .m0_we(we_in[1][0]), .m0_addr(addr_in[1][0]),
    .m0_size(size_in[1][0]), .m0_wdata(wdata_in[1][0]),
    .m1_req(req[1][1]), .m1_we(we_in[1][1]), .m1_addr(addr_in[1][1]),
    .m1_size(size_in[1][1]), .m1_wdata(wdata_in[1][1]),
    .m0_gnt(gnt[1][0]), .m0_done(done[1][0]), .m0_err(err[1][0]), .m0_rdata(rdata[1][0]),
    .m1_gnt(gnt[1][1]), .m1_done(done[1][1]), .m1_err(err[1][1]), .m1_rdata(rdata[1][1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_size(mem_size[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata_b),
    .core_stall(stall[1])
`ifdef DMEM_ARB_STATS_EN
    , .m0_count(count[1][0]), .m1_count(count[1][1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_busy    [2];
  bit          m_owner   [2];
  bit          m_last    [2];
  bit          m_ok      [2];
  int unsigned m_start   [2];
  int unsigned m_done_at [2];
  logic        m_we      [2];
  logic [31:0] m_addr    [2];
  logic [1:0]  m_size    [2];
  logic [31:0] m_wdata   [2];
  int unsigned m_cnt     [2][2];

  function automatic bit legal(input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'd0:    return 1'b1;
      2'd1:    return (a % 2) == 0;
      2'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic [31:0] read_value(input int i);
    if (i == 0) return store[m_addr[0][7:2]];
    return {16'hC0DE, 16'(m_start[1] + 1 + LAT_B)};
  endfunction

  task automatic model_step(input int i);
    logic [1:0]  e_gnt, e_done, e_err;
    logic        e_en, e_stall;
    logic [31:0] e_rd;
    bit          r0, r1, wn;
    string       tag;
    tag     = (i == 0) ? "A" : "B";
    r0      = (req[i][0] === 1'b1);
    r1      = (req[i][1] === 1'b1);
    e_gnt   = '0;
    e_done  = '0;
    e_err   = '0;
    e_en    = 1'b0;
    e_rd    = '0;
    if (reset !== 1'b1) begin
      m_busy[i]  = 1'b0;
      m_last[i]  = 1'b1;
      m_we[i]    = 1'b0;
      m_addr[i]  = '0;
      m_size[i]  = '0;
      m_wdata[i] = '0;
      m_cnt[i][0] = 0;
      m_cnt[i][1] = 0;
    end else if (m_busy[i]) begin
      e_gnt[m_owner[i]] = 1'b1;
      e_en = m_ok[i] && (cyc == m_start[i] + 1);
      if (cyc == m_done_at[i]) begin
        e_done[m_owner[i]] = 1'b1;
        e_err[m_owner[i]]  = !m_ok[i];
        if (m_ok[i] && !m_we[i]) e_rd = read_value(i);
      end
    end
    e_stall = r0 && !e_done[0];

    chk({tag, ".gnt"},   {gnt[i][1], gnt[i][0]},   e_gnt);
    chk({tag, ".done"},  {done[i][1], done[i][0]}, e_done);
    chk({tag, ".mem_en"}, mem_en[i], e_en);
    chk({tag, ".mem_we_size"}, {mem_we[i], mem_size[i]}, {m_we[i], m_size[i]});
    chk({tag, ".mem_addr"},  mem_addr[i],  m_addr[i]);
    chk({tag, ".mem_wdata"}, mem_wdata[i], m_wdata[i]);
    chk({tag, ".core_stall"}, stall[i], e_stall);
    if (reset !== 1'b1 || e_done[0]) begin
      chk({tag, ".m0_err"},   err[i][0],   e_err[0]);
      chk({tag, ".m0_rdata"}, rdata[i][0], e_done[0] ? e_rd : 32'h0);
    end
    if (reset !== 1'b1 || e_done[1]) begin
      chk({tag, ".m1_err"},   err[i][1],   e_err[1]);
      chk({tag, ".m1_rdata"}, rdata[i][1], e_done[1] ? e_rd : 32'h0);
    end
`ifdef DMEM_ARB_STATS_EN
    chk({tag, ".m0_count"}, count[i][0], 16'(m_cnt[i][0]));
    chk({tag, ".m1_count"}, count[i][1], 16'(m_cnt[i][1]));
`endif

    if (reset === 1'b1) begin
      if (m_busy[i]) begin
        if (cyc == m_done_at[i]) begin
          m_busy[i] = 1'b0;
          if (m_ok[i] && m_cnt[i][m_owner[i]] < 65535) m_cnt[i][m_owner[i]]++;
        end
      end else if (r0 || r1) begin
        wn           = (r0 && r1) ? !m_last[i] : r1;
        m_owner[i]   = wn;
        m_last[i]    = wn;
        m_we[i]      = we_in[i][wn];
        m_addr[i]    = addr_in[i][wn];
        m_size[i]    = size_in[i][wn];
        m_wdata[i]   = wdata_in[i][wn];
        m_ok[i]      = legal(m_size[i], m_addr[i]);
        m_start[i]   = cyc;
        m_done_at[i] = !m_ok[i] ? cyc + 1 : (m_we[i] ? cyc + 2 : cyc + 2 + lat_of(i));
        m_busy[i]    = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- stimulus ----------------
  task automatic start_req(input int i, input int p, input logic w, input logic [31:0] a,
                           input logic [1:0] s, input logic [31:0] d, output int unsigned rc);
    we_in[i][p]    = w;
    addr_in[i][p]  = a;
    size_in[i][p]  = s;
    wdata_in[i][p] = d;
    req[i][p]      = 1'b1;
    rc             = cyc;
  endtask

  // Waits (bounded) for port p's done; reports offsets relative to the
  // request cycle rc, then drops the request in the following IDLE cycle.
  task automatic wait_done(input int i, input int p, input int unsigned rc,
                           output int lat, output int en_at, output logic [31:0] en_addr,
                           output logic [31:0] rd, output logic er);
    lat = -1; en_at = -1; en_addr = '0; rd = '0; er = 1'b0;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (mem_en[i] === 1'b1 && en_at < 0) begin
        en_at   = int'(cyc - rc);
        en_addr = mem_addr[i];
      end
      if (done[i][p] === 1'b1) begin
        lat = int'(cyc - rc);
        rd  = rdata[i][p];
        er  = err[i][p];
      end
    end
    @(posedge clk);
    #1 req[i][p] = 1'b0;
  endtask

  task automatic collect(input int i, output logic [3:0] order, output int n);
    bit prev;
    n = 0; prev = 1'b0; order = '0;
    for (int k = 0; k < 80 && n < 4; k++) begin
      @(negedge clk);
      if (prev) chk("idle_after_done", {gnt[i][1], gnt[i][0]}, 2'b00);
      prev = 1'b0;
      if (done[i][0] === 1'b1) begin order[n] = 1'b0; n++; prev = 1'b1; end
      else if (done[i][1] === 1'b1) begin order[n] = 1'b1; n++; prev = 1'b1; end
    end
    @(posedge clk);
    #1 begin req[i][0] = 1'b0; req[i][1] = 1'b0; end
  endtask

  initial begin
    int          lat, en_at, n;
    int unsigned rc;
    logic [31:0] ea, rd;
    logic        er;
    logic [3:0]  order;

    reset = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we_in[i][p] = 1'b0; addr_in[i][p] = '0;
        size_in[i][p] = '0; wdata_in[i][p] = '0;
      end

    // Reset, then idle.
    repeat (3) @(negedge clk);
    chk("reset_ctrl_A", {gnt[0][0], gnt[0][1], done[0][0], done[0][1], err[0][0], err[0][1],
                         mem_en[0], mem_we[0], mem_size[0], stall[0]}, 0);
    chk("reset_addr_B", mem_addr[1], 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_gnt", {gnt[0][0], gnt[0][1], gnt[1][0], gnt[1][1], mem_en[0], mem_en[1]}, 0);

    // A (latency 1): word write then read-back on port 0.
    @(posedge clk); #1;
    start_req(0, 0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF, rc);
    wait_done(0, 0, rc, lat, en_at, ea, rd, er);
    chk("wr_en_offset", en_at, 1);
    chk("wr_en_addr", ea, 32'h10);
    chk("wr_done_lat", lat, 2);
    chk("wr_err", er, 0);

    start_req(0, 0, 1'b0, 32'h10, 2'd2, 32'h0, rc);
    @(negedge clk);
    chk("rd_stall_high", stall[0], 1'b1);
    wait_done(0, 0, rc, lat, en_at, ea, rd, er);
    chk("rd_done_lat", lat, 3);
    chk("rd_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_stall_low", stall[0], 1'b0);

    // B (latency 3): port 1 read returns the value presented 3 cycles after mem_en.
    @(posedge clk); #1;
    start_req(1, 1, 1'b0, 32'h40, 2'd2, 32'h0, rc);
    wait_done(1, 1, rc, lat, en_at, ea, rd, er);
    chk("b_rd_en_offset", en_at, 1);
    chk("b_rd_done_lat", lat, 5);
    chk("b_rd_data", rd, {16'hC0DE, 16'(rc + 4)});

    // Rejected requests: no memory strobe, done one cycle after the request.
    start_req(0, 0, 1'b0, 32'h13, 2'd1, 32'h0, rc);
    wait_done(0, 0, rc, lat, en_at, ea, rd, er);
    chk("half_odd_lat", lat, 1);
    chk("half_odd_err", er, 1'b1);
    chk("half_odd_rdata", rd, 32'h0);
    chk("half_odd_no_en", en_at, -1);

    start_req(0, 1, 1'b0, 32'h0, 2'd3, 32'h0, rc);
    wait_done(0, 1, rc, lat, en_at, ea, rd, er);
    chk("size3_lat", lat, 1);
    chk("size3_err", er, 1'b1);
    chk("size3_no_en", en_at, -1);

    start_req(1, 0, 1'b1, 32'h2, 2'd2, 32'h12345678, rc);
    wait_done(1, 0, rc, lat, en_at, ea, rd, er);
    chk("word_mis_err", er, 1'b1);
    chk("word_mis_lat", lat, 1);

    start_req(1, 0, 1'b1, 32'h13, 2'd0, 32'h000000A5, rc);
    wait_done(1, 0, rc, lat, en_at, ea, rd, er);
    chk("byte_odd_err", er, 1'b0);
    chk("byte_odd_lat", lat, 2);

    // Request dropped after acceptance still completes.
    start_req(1, 1, 1'b0, 32'h8, 2'd2, 32'h0, rc);
    @(posedge clk); #1 req[1][1] = 1'b0;
    wait_done(1, 1, rc, lat, en_at, ea, rd, er);
    chk("drop_done_lat", lat, 5);

    // Reset during WAIT on B, then both ports requesting: 0,1,0,1.
    start_req(1, 0, 1'b0, 32'h44, 2'd2, 32'h0, rc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    start_req(1, 1, 1'b1, 32'h48, 2'd2, 32'h5555AAAA, rc);
    #1;
    chk("abort_gnt", {gnt[1][0], gnt[1][1], done[1][0], done[1][1], mem_en[1]}, 0);
    chk("abort_addr", mem_addr[1], 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    collect(1, order, n);
    chk("alt_count", n, 4);
    chk("alt_order", order, 4'b1010);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
